// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared widths, lock state encoding and saturating increment for sync_blank_gen
package video_timing_pkg;

  localparam int HCNT_W_DEF = 10;
  localparam int VCNT_W_DEF = 9;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_H_OK     = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] maxv);
    return (v >= maxv) ? maxv : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_axis_cnt.sv
// rtl/sync_axis_cnt.sv - one timing axis: sync edge clear, saturating count, total latch, blank window
module sync_axis_cnt
  import video_timing_pkg::*;
#(
  parameter int W           = 10,
  parameter int WIN_LO      = 0,
  parameter int WIN_HI      = 1,
  parameter bit TOTAL_PLUS1 = 1'b0
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         i_ce,
  input  logic         i_sync,
  input  logic         i_inc,
  output logic         o_sync_d,
  output logic         o_rise,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_total,
  output logic         o_blank
);

  localparam logic [31:0] CNT_MAX = (32'd1 << W) - 32'd1;
  localparam logic [31:0] LO      = WIN_LO;
  localparam logic [31:0] HI      = WIN_HI;

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_total;
  logic         r_sync_d;
  logic [W-1:0] w_cnt_inc;
  logic [31:0]  w_cnt32;
  logic         w_rise;

  assign w_cnt32   = 32'(r_cnt);
  assign w_cnt_inc = W'(sat_inc(w_cnt32, CNT_MAX));
  assign w_rise    = i_sync & ~r_sync_d;

  // Edge clear outranks the increment; the counter never wraps.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_cnt    <= '0;
      r_total  <= '0;
      r_sync_d <= 1'b0;
    end else if (i_ce) begin
      r_sync_d <= i_sync;
      if (w_rise) begin
        r_cnt   <= '0;
        r_total <= TOTAL_PLUS1 ? w_cnt_inc : r_cnt;
      end else if (i_inc) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign o_sync_d = r_sync_d;
  assign o_rise   = w_rise;
  assign o_cnt    = r_cnt;
  assign o_total  = r_total;
  assign o_blank  = (w_cnt32 < LO) | (w_cnt32 >= HI);

endmodule

// File: rtl/sync_blank_gen.sv
// rtl/sync_blank_gen.sv - HBlank/VBlank from raw syncs by counting pixel enables, with measured totals and lock
module sync_blank_gen
  import video_timing_pkg::*;
#(
  parameter int HCNT_W     = HCNT_W_DEF,
  parameter int VCNT_W     = VCNT_W_DEF,
  parameter int H_START    = 34,
  parameter int H_END      = 214,
  parameter int V_START    = 25,
  parameter int V_END      = 254,
  parameter int LOCK_LINES = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic              hsync_i,
  input  logic              vsync_i,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              hblank_o,
  output logic              vblank_o,
  output logic [HCNT_W-1:0] h_total,
  output logic [VCNT_W-1:0] v_total,
  output logic              locked
);

  if (!((H_START < H_END) && (H_END < (1 << HCNT_W)) &&
        (V_START <= V_END) && (V_END < (1 << VCNT_W)) &&
        (LOCK_LINES >= 2) && (LOCK_LINES <= 15))) begin : g_param_check
    $error("sync_blank_gen: invalid timing parameters");
  end

  localparam logic [31:0] H_CNT_MAX = (32'd1 << HCNT_W) - 32'd1;
  localparam logic [3:0]  STAB_LOCK = 4'(LOCK_LINES - 1);

  logic [HCNT_W-1:0] w_hcnt;
  logic [VCNT_W-1:0] w_vcnt;
  logic [HCNT_W-1:0] w_h_total_nxt;
  logic              w_h_rise_raw;
  logic              w_v_rise_raw;
  logic              w_h_rise;
  logic              w_v_rise;
  logic              w_hsat;
  logic              w_line_ok;
  logic              w_h_bad;
  logic              w_v_match;

  lock_state_t r_state;
  lock_state_t w_state_nxt;
  logic [3:0]  r_stab;
  logic [3:0]  w_stab_nxt;

  sync_axis_cnt #(
    .W           (HCNT_W),
    .WIN_LO      (H_START),
    .WIN_HI      (H_END),
    .TOTAL_PLUS1 (1'b1)
  ) u_h_axis (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .i_ce     (ce_pix),
    .i_sync   (hsync_i),
    .i_inc    (1'b1),
    .o_sync_d (hsync_o),
    .o_rise   (w_h_rise_raw),
    .o_cnt    (w_hcnt),
    .o_total  (h_total),
    .o_blank  (hblank_o)
  );

  // The line axis counts HSync rises; its own VSync clear takes priority.
  sync_axis_cnt #(
    .W           (VCNT_W),
    .WIN_LO      (V_START),
    .WIN_HI      (V_END + 1),
    .TOTAL_PLUS1 (1'b0)
  ) u_v_axis (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .i_ce     (ce_pix),
    .i_sync   (vsync_i),
    .i_inc    (w_h_rise_raw),
    .o_sync_d (vsync_o),
    .o_rise   (w_v_rise_raw),
    .o_cnt    (w_vcnt),
    .o_total  (v_total),
    .o_blank  (vblank_o)
  );

  assign w_h_rise      = ce_pix & w_h_rise_raw;
  assign w_v_rise      = ce_pix & w_v_rise_raw;
  assign w_hsat        = &w_hcnt;
  assign w_h_total_nxt = HCNT_W'(sat_inc(32'(w_hcnt), H_CNT_MAX));
  assign w_line_ok     = (w_h_total_nxt == h_total) & ~w_hsat;
  assign w_h_bad       = (ce_pix & w_hsat) | (w_h_rise & ~w_line_ok);
  assign w_v_match     = (w_vcnt == v_total);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= ST_UNLOCKED;
      r_stab  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_stab  <= w_stab_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stab_nxt  = r_stab;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_h_bad) begin
          w_stab_nxt = 4'd0;
        end else if (w_h_rise) begin
          w_stab_nxt = r_stab + 4'd1;
          if ((r_stab + 4'd1) == STAB_LOCK) begin
            w_state_nxt = ST_H_OK;
          end
        end
      end
      ST_H_OK: begin
        if (w_h_bad) begin
          w_state_nxt = ST_UNLOCKED;
          w_stab_nxt  = 4'd0;
        end else if (w_v_rise & w_v_match) begin
          w_state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_h_bad | (w_v_rise & ~w_v_match)) begin
          w_state_nxt = ST_UNLOCKED;
          w_stab_nxt  = 4'd0;
        end
      end
      default: begin
        w_state_nxt = ST_UNLOCKED;
        w_stab_nxt  = 4'd0;
      end
    endcase
  end

  assign locked = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_sync_blank_gen.sv
// tb/tb_sync_blank_gen.sv - self-checking bench for sync_blank_gen against a per-ce reference model
module tb_sync_blank_gen;

  localparam int HW   = 10;
  localparam int VW   = 9;
  localparam int HS   = 34;
  localparam int HE   = 214;
  localparam int VS   = 25;
  localparam int VE   = 254;
  localparam int LL   = 4;
  localparam int HMAX = (1 << HW) - 1;
  localparam int VMAX = (1 << VW) - 1;

  logic          clk_sys = 1'b0;
  logic          reset   = 1'b1;
  logic          ce_pix  = 1'b0;
  logic          hsync_i = 1'b0;
  logic          vsync_i = 1'b0;
  logic          hsync_o, vsync_o, hblank_o, vblank_o, locked;
  logic [HW-1:0] h_total;
  logic [VW-1:0] v_total;

  sync_blank_gen #(
    .HCNT_W(HW), .VCNT_W(VW), .H_START(HS), .H_END(HE),
    .V_START(VS), .V_END(VE), .LOCK_LINES(LL)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ce_pix   (ce_pix),
    .hsync_i  (hsync_i),
    .vsync_i  (vsync_i),
    .hsync_o  (hsync_o),
    .vsync_o  (vsync_o),
    .hblank_o (hblank_o),
    .vblank_o (vblank_o),
    .h_total  (h_total),
    .v_total  (v_total),
    .locked   (locked)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;
  int ce_div   = 1;
  int nvis     = 0;

  // Reference state: counters, totals, and the length of the current run of matching lines.
  int m_hcnt, m_vcnt, m_htot, m_vtot, m_run;
  bit m_hs, m_vs, m_locked;

  typedef struct {
    bit is_v;
    int n;
    bit exp_blank;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hcnt = 0; m_vcnt = 0; m_htot = 0; m_vtot = 0; m_run = 0;
    m_hs = 0; m_vs = 0; m_locked = 0;
  endtask

  task automatic model_ce(input bit hs, input bit vs);
    bit hr, vr, hsat, brk, hok, vmatch;
    int newtot, old_vcnt;
    hr       = hs && !m_hs;
    vr       = vs && !m_vs;
    hsat     = (m_hcnt == HMAX);
    newtot   = hsat ? HMAX : m_hcnt + 1;
    hok      = (m_run >= LL - 1);
    vmatch   = (m_vcnt == m_vtot);
    old_vcnt = m_vcnt;
    brk      = hsat;
    if (hr) begin
      if (newtot == m_htot && !hsat) m_run++;
      else brk = 1;
    end
    if (brk) begin
      m_run = 0; m_locked = 0;
    end else if (vr) begin
      if (m_locked && !vmatch) begin
        m_locked = 0; m_run = 0;
      end else if (hok && vmatch) begin
        m_locked = 1;
      end
    end
    if (hr) begin
      m_htot = newtot;
      m_hcnt = 0;
      m_vcnt = (m_vcnt == VMAX) ? VMAX : m_vcnt + 1;
    end else begin
      m_hcnt = hsat ? HMAX : m_hcnt + 1;
    end
    if (vr) begin
      m_vtot = old_vcnt;
      m_vcnt = 0;
    end
    m_hs = hs; m_vs = vs;
  endtask

  task automatic check_all();
    chk("hsync_o",  hsync_o,  m_hs);
    chk("vsync_o",  vsync_o,  m_vs);
    chk("hblank_o", hblank_o, (m_hcnt >= HE) || (m_hcnt < HS));
    chk("vblank_o", vblank_o, (m_vcnt < VS) || (m_vcnt > VE));
    chk("h_total",  h_total,  m_htot);
    chk("v_total",  v_total,  m_vtot);
    chk("locked",   locked,   m_locked);
  endtask

  task automatic step(input bit ce, input bit hs, input bit vs, input bit rst);
    reset = rst; ce_pix = ce; hsync_i = hs; vsync_i = vs;
    @(posedge clk_sys);
    if (rst) model_reset();
    else if (ce) model_ce(hs, vs);
    #1;
    check_all();
  endtask

  task automatic px(input bit hs, input bit vs);
    if (ce_div == 2) step(1'b0, hs, vs, 1'b0);
    step(1'b1, hs, vs, 1'b0);
    if (!hblank_o) nvis++;
  endtask

  task automatic line(input int len, input bit vs);
    for (int i = 0; i < len; i++) px(i < 32, vs);
  endtask

  task automatic frame(input int lines, input int len);
    for (int l = 0; l < lines; l++) line(len, l < 3);
  endtask

  initial begin
    vecs = '{'{1'b0, 33, 1'b1}, '{1'b0, 34, 1'b0}, '{1'b0, 213, 1'b0}, '{1'b0, 214, 1'b1},
             '{1'b1, 24, 1'b1}, '{1'b1, 25, 1'b0}, '{1'b1, 254, 1'b0}, '{1'b1, 255, 1'b1}};

    // T1 reset with ce active
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t1_hblank", hblank_o, 1);
    chk("t1_vblank", vblank_o, 1);
    chk("t1_locked", locked, 0);
    chk("t1_h_total", h_total, 0);

    // T3 window edges
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (!vecs[k].is_v) begin
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (vecs[k].n) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk($sformatf("t3_hblank_%0d", vecs[k].n), hblank_o, vecs[k].exp_blank);
      end else begin
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (vecs[k].n) begin
          step(1'b1, 1'b1, 1'b1, 1'b0);
          step(1'b1, 1'b0, 1'b1, 1'b0);
        end
        chk($sformatf("t3_vblank_%0d", vecs[k].n), vblank_o, vecs[k].exp_blank);
      end
    end

    // T2/T4 nominal timing, ce every 2nd clock, VSync rising with HSync
    ce_div = 2;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) frame(16, 240);
    nvis = 0;
    line(240, 1'b1);
    chk("t2_visible_px", nvis, HE - HS);
    chk("t2_h_total", h_total, 240);
    chk("t4_v_total", v_total, 15);
    chk("t2_locked", locked, 1);
    line(239, 1'b1);
    line(240, 1'b1);
    chk("t2_short_line_unlock", locked, 0);

    // T5 sync loss and relock
    ce_div = 1;
    repeat (3) frame(8, 240);
    line(240, 1'b1);
    chk("t5_locked_before", locked, 1);
    repeat (1100) px(1'b0, 1'b0);
    chk("t5_hblank_sat", hblank_o, 1);
    chk("t5_locked_lost", locked, 0);
    line(240, 1'b0);
    chk("t5_h_total_sat", h_total, HMAX);
    repeat (3) frame(8, 240);
    chk("t5_relocked", locked, 1);

    // T6 reset mid-line, then ce held low
    ce_div = 2;
    line(101, 1'b0);
    chk("t6_locked_pre", locked, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_locked", locked, 0);
    chk("t6_hblank", hblank_o, 1);
    chk("t6_h_total", h_total, 0);
    repeat (50) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

    // Randomised syncs, enables and occasional resets
    begin
      bit hs, vs;
      hs = 0; vs = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 11) == 0) hs = ~hs;
        if ($urandom_range(0, 60) == 0) vs = ~vs;
        step(1'($urandom_range(0, 3) != 0), hs, vs, 1'($urandom_range(0, 599) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
